// File: rtl/pwm_seq_pkg.sv
// Shared types for the PWM playback sequencer.
package pwm_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_seq_prescaler.sv
// Clock prescaler for the PWM counter: ticks once every limit+1 clocks while running.
module pwm_seq_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               run,
  input  logic [PRESC_W-1:0] limit,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_lim_q;

  // The limit is frozen at each load so a mid-period prescale change waits for the next entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      presc_lim_q <= '0;
    end else if (load) begin
      presc_q     <= '0;
      presc_lim_q <= limit;
    end else if (run) begin
      presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
    end
  end

  assign tick = run && (presc_q == presc_lim_q);

endmodule

// File: rtl/pwm_seq.sv
// Plays the programmed word memory back as a train of PWM periods, one word per period.
// Optional feature: define PWM_SEQ_LOOP_EN to add loop_i (restart at address 0 instead of stopping).
module pwm_seq
  import pwm_seq_pkg::*;
#(
  parameter int WIDTH   = 7,
  parameter int DEPTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic                     programmed_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [$clog2(DEPTH)-1:0] addr_o,
  input  logic [$clog2(DEPTH)-1:0] length_i,
  input  logic [PRESC_W-1:0]       prescale_i,
`ifdef PWM_SEQ_LOOP_EN
  input  logic                     loop_i,
`endif
  output logic                     pwm_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] CNT_LAST  = WIDTH'((2 ** WIDTH) - 2);

  state_e state_q, state_d;

  logic [AW-1:0]    len_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] cnt_q;
  logic [AW-1:0]    len_in;
  logic             tick;
  logic             run_ok;
  logic             period_end;
  logic             last_entry;
  logic             wrap;
  logic             pwm, busy, done;

  if ((2 ** AW) == DEPTH) begin : g_len_pow2
    assign len_in = length_i;
  end else begin : g_len_clamp
    assign len_in = (length_i > LAST_ADDR) ? LAST_ADDR : length_i;
  end

`ifdef PWM_SEQ_LOOP_EN
  assign wrap = loop_i;
`else
  assign wrap = 1'b0;
`endif

  assign run_ok     = enable_i && programmed_i;
  assign period_end = (state_q == StRun) && tick && (cnt_q == CNT_LAST);
  assign last_entry = (addr_q == len_q);

  pwm_seq_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state_q == StLoad),
    .run  (state_q == StRun),
    .limit(prescale_i),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort is checked before period end so a coincident disable always lands in StIdle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (run_ok) state_d = StLoad;
      StLoad: state_d = run_ok ? StRun : StIdle;
      StRun: begin
        if (!run_ok) begin
          state_d = StIdle;
        end else if (period_end) begin
          state_d = (last_entry && !wrap) ? StDone : StLoad;
        end
      end
      StDone: if (!enable_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pwm  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      StLoad: busy = 1'b1;
      StRun: begin
        busy = 1'b1;
        pwm  = (cnt_q < duty_q);
      end
      StDone: done = 1'b1;
      default: ;
    endcase
  end

  // Leaving for StIdle clears the address at once so an aborted run shows address 0 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      addr_q <= '0;
      duty_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          addr_q <= '0;
          if (run_ok) len_q <= len_in;
        end
        StLoad: begin
          duty_q <= data_i;
          cnt_q  <= '0;
        end
        StRun: begin
          if (tick) cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + WIDTH'(1);
          if (run_ok && period_end && (!last_entry || wrap)) begin
            addr_q <= last_entry ? '0 : addr_q + AW'(1);
          end
        end
        default: ;
      endcase
      if (state_d == StIdle) addr_q <= '0;
    end
  end

  assign addr_o = addr_q;
  assign pwm_o  = pwm;
  assign busy_o = busy;
  assign done_o = done;

endmodule

// File: tb/tb_pwm_seq.sv
// Scoreboard bench for pwm_seq: per-cycle expected {pwm, busy, done, addr} queued at stimulus time.
module tb_pwm_seq;

  localparam int WIDTH   = 7;
  localparam int DEPTH   = 32;
  localparam int PRESC_W = 8;
  localparam int AW      = 5;
  localparam int STEPS   = 127;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable_i = 1'b0;
  logic               programmed_i = 1'b0;
  logic [WIDTH-1:0]   data_i;
  logic [AW-1:0]      addr_o;
  logic [AW-1:0]      length_i = '0;
  logic [PRESC_W-1:0] prescale_i = '0;
  logic               pwm_o, busy_o, done_o;
`ifdef PWM_SEQ_LOOP_EN
  logic               loop_i = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW+2:0]    exp_q [$];
  int               compared = 0;
  int               mismatched = 0;

  always #5 clk = ~clk;

  assign data_i = mem[addr_o];

  pwm_seq #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .programmed_i(programmed_i),
    .data_i      (data_i),
    .addr_o      (addr_o),
    .length_i    (length_i),
    .prescale_i  (prescale_i),
`ifdef PWM_SEQ_LOOP_EN
    .loop_i      (loop_i),
`endif
    .pwm_o       (pwm_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic prog, input int len, input int presc);
    enable_i     = en;
    programmed_i = prog;
    length_i     = AW'(len);
    prescale_i   = PRESC_W'(presc);
  endtask

  task automatic push_cycles(input int n, input logic pwm, input logic busy, input logic done,
                             input int addr);
    for (int i = 0; i < n; i++) exp_q.push_back({pwm, busy, done, AW'(addr)});
  endtask

  // One entry: a load cycle, then 127 counter steps each lasting presc+1 clocks.
  task automatic push_period(input int duty, input int presc, input int addr);
    push_cycles(1, 1'b0, 1'b1, 1'b0, addr);
    for (int k = 0; k < STEPS * (presc + 1); k++) begin
      push_cycles(1, (k / (presc + 1)) < duty, 1'b1, 1'b0, addr);
    end
  endtask

  task automatic drain(input string tag, input int n);
    logic [AW+2:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checkOutput({tag, "_underrun"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput(tag, {pwm_o, busy_o, done_o, addr_o}, e);
      end
    end
  endtask

  task automatic drain_all(input string tag);
    drain(tag, exp_q.size());
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Reset state
    #1;
    checkOutput("reset_outputs", {pwm_o, busy_o, done_o, addr_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_cycles(2, 1'b0, 1'b0, 1'b0, 0);
    drain_all("idle_after_reset");

    // Single entry, duty 32; a length change mid-run must not affect this run
    mem[0] = 7'd32;
    applyStimulus(1'b1, 1'b1, 0, 0);
    push_period(32, 0, 0);
    drain("single_start", 10);
    length_i = AW'(3);
    push_cycles(3, 1'b0, 1'b0, 1'b1, 0);
    drain_all("single_entry");
    enable_i = 1'b0;
    push_cycles(2, 1'b0, 1'b0, 1'b0, 0);
    drain_all("single_exit");

    // Extremes; prescale change mid-entry applies from the next load
    mem[0] = 7'd0;
    mem[1] = 7'd127;
    applyStimulus(1'b1, 1'b1, 1, 0);
    push_period(0, 0, 0);
    drain("extreme_p0_start", 10);
    prescale_i = PRESC_W'(1);
    push_period(127, 1, 1);
    push_cycles(2, 1'b0, 1'b0, 1'b1, 1);
    drain_all("extremes");
    enable_i = 1'b0;
    push_cycles(2, 1'b0, 1'b0, 1'b0, 0);
    drain_all("extremes_exit");

    // Multi-entry with prescaler 1
    mem[0] = 7'd10;
    mem[1] = 7'd64;
    mem[2] = 7'd100;
    applyStimulus(1'b1, 1'b1, 2, 1);
    push_period(10, 1, 0);
    push_period(64, 1, 1);
    push_period(100, 1, 2);
    push_cycles(3, 1'b0, 1'b0, 1'b1, 2);
    drain_all("multi_entry");
    enable_i = 1'b0;
    push_cycles(2, 1'b0, 1'b0, 1'b0, 0);
    drain_all("multi_exit");

    // Abort by programmed_i during entry 1
    mem[0] = 7'd0;
    mem[1] = 7'd127;
    applyStimulus(1'b1, 1'b1, 1, 0);
    push_period(0, 0, 0);
    push_cycles(1, 1'b0, 1'b1, 1'b0, 1);
    push_cycles(50, 1'b1, 1'b1, 1'b0, 1);
    drain_all("abort_prog_run");
    programmed_i = 1'b0;
    push_cycles(2, 1'b0, 1'b0, 1'b0, 0);
    drain_all("abort_prog");
    applyStimulus(1'b0, 1'b1, 1, 0);
    push_cycles(1, 1'b0, 1'b0, 1'b0, 0);
    drain_all("abort_prog_idle");

    // Abort by enable_i
    applyStimulus(1'b1, 1'b1, 1, 0);
    push_period(0, 0, 0);
    push_cycles(1, 1'b0, 1'b1, 1'b0, 1);
    push_cycles(50, 1'b1, 1'b1, 1'b0, 1);
    drain_all("abort_en_run");
    enable_i = 1'b0;
    push_cycles(2, 1'b0, 1'b0, 1'b0, 0);
    drain_all("abort_en");

    // Asynchronous reset mid-run
    mem[0] = 7'd64;
    applyStimulus(1'b1, 1'b1, 0, 0);
    push_cycles(1, 1'b0, 1'b1, 1'b0, 0);
    push_cycles(20, 1'b1, 1'b1, 1'b0, 0);
    drain_all("pre_async_reset");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {pwm_o, busy_o, done_o, addr_o}, 32'd0);
    enable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_cycles(2, 1'b0, 1'b0, 1'b0, 0);
    drain_all("idle_after_async_reset");

`ifdef PWM_SEQ_LOOP_EN
    // Looping: 0,1,2,0,1 then loop dropped during entry 2 ends the sequence
    mem[0] = 7'd20;
    mem[1] = 7'd40;
    mem[2] = 7'd60;
    loop_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 2, 0);
    push_period(20, 0, 0);
    push_period(40, 0, 1);
    push_period(60, 0, 2);
    push_period(20, 0, 0);
    push_period(40, 0, 1);
    drain_all("loop_run");
    push_period(60, 0, 2);
    drain("loop_last", 50);
    loop_i = 1'b0;
    push_cycles(2, 1'b0, 1'b0, 1'b1, 2);
    drain_all("loop_stop");
    enable_i = 1'b0;
    push_cycles(1, 1'b0, 1'b0, 1'b0, 0);
    drain_all("loop_exit");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
